ps2_frame_rx: RTL

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_rx_fifo.sv | 69 ++++++
 rtl/ps2_frame_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 frame receiver and its FIFO.
//   ps2_state_e   - receiver FSM state encoding (also used for the debug port)
//   PS2_DATA_BITS - data bits per PS/2 frame
//   parity_ok()   - odd-parity check over the data byte plus its parity bit
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit contain an odd number of ones.
    function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                       input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: first-word fall-through FIFO for received bytes.
//   clk, rst      - clock, synchronous active-high reset
//   push, wdata   - write request and data (ignored when full unless popping)
//   pop           - read request (ignored when empty)
//   rdata         - head entry, read combinationally from storage
//   full, empty   - occupancy flags
//   level         - current occupancy, 0..DEPTH
module ps2_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A pop frees the slot being written, so a full FIFO still accepts a push
    // in the same cycle as a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with a receive FIFO.
//   clk, rst      - system clock, synchronous active-high reset
//   ps2_clk       - raw asynchronous PS/2 clock line
//   ps2_data      - raw asynchronous PS/2 data line
//   rx_data       - head-of-FIFO byte
//   rx_valid      - FIFO not empty
//   rx_ready      - consumer accepts rx_data
//   rx_level      - FIFO occupancy
//   parity_err    - one-cycle pulse, frame dropped for bad odd parity
//   frame_err     - one-cycle pulse, frame dropped for a zero stop bit
//   timeout_err   - one-cycle pulse, frame aborted by bus inactivity
//   overflow      - sticky, a good byte was lost to a full FIFO
//   clr_overflow  - clears overflow (a same-cycle set wins)
//   state_dbg     - current receiver FSM state
//
// Handshake: rx_valid/rx_ready follow strict valid/ready rules. rx_valid and
// rx_data do not depend on rx_ready; a byte is consumed in every cycle where
// both are high, and rx_data holds while rx_valid is high and no pop occurs.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output ps2_state_e                    state_dbg
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W = $clog2(PS2_DATA_BITS);

    // ---------------- synchronisers and clock filter ----------------
    logic [SYNC_STAGES-1:0] clk_sreg;
    logic [SYNC_STAGES-1:0] data_sreg;
    logic                   clk_s;
    logic                   data_s;
    logic [FLT_W-1:0]       flt_cnt;
    logic                   clk_flt;
    logic                   clk_flt_q;
    logic                   fall_edge;
    logic                   any_edge;

    assign clk_s  = clk_sreg[SYNC_STAGES-1];
    assign data_s = data_sreg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sreg  <= '1;
            data_sreg <= '1;
            flt_cnt   <= '0;
            clk_flt   <= 1'b1;
            clk_flt_q <= 1'b1;
        end else begin
            clk_sreg  <= {clk_sreg[SYNC_STAGES-2:0], ps2_clk};
            data_sreg <= {data_sreg[SYNC_STAGES-2:0], ps2_data};
            clk_flt_q <= clk_flt;
            // flt_cnt counts consecutive samples that disagree with clk_flt;
            // any agreeing sample restarts the run, rejecting short glitches.
            if (clk_s == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_flt <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    assign fall_edge = clk_flt_q & ~clk_flt;
    assign any_edge  = clk_flt_q ^ clk_flt;

    // ---------------- frame FSM ----------------
    ps2_state_e                 state;
    ps2_state_e                 state_nx;
    logic [BIT_W-1:0]           bit_cnt;
    logic [PS2_DATA_BITS-1:0]   shift_q;
    logic                       par_q;
    logic [TMO_W-1:0]           tmo_cnt;
    logic                       tmo_hit;
    logic                       stop_evt;
    logic                       par_good;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       empty;

    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        tmo_hit  = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
        stop_evt = 1'b0;
        par_good = parity_ok(shift_q, par_q);
        push     = 1'b0;
        if (tmo_hit) begin
            state_nx = IDLE;
        end else if (fall_edge) begin
            case (state)
                IDLE:    if (!data_s) state_nx = DATA;
                DATA:    if (bit_cnt == BIT_W'(PS2_DATA_BITS - 1)) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    stop_evt = 1'b1;
                    push     = par_good & data_s;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_cnt     <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            parity_err  <= stop_evt & ~par_good;
            frame_err   <= stop_evt & ~data_s;
            timeout_err <= tmo_hit;

            // Inactivity timer runs only inside a frame; any filtered edge restarts it.
            if (state == IDLE || tmo_hit || any_edge) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (tmo_hit) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (fall_edge) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shift_q <= {data_s, shift_q[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    PARITY: par_q <= data_s;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- receive FIFO and overflow flag ----------------
    assign pop      = rx_valid & rx_ready;
    assign rx_valid = ~empty;

    ps2_rx_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (rx_data),
        .full  (full),
        .empty (empty),
        .level (rx_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
